// File: rtl/scan_dec_pkg.sv
// scan_dec_pkg: shared state encoding, default constants and one-cold helper for the scan decoder family
package scan_dec_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        DIRECT = ST_DIRECT,
        SCAN   = ST_SCAN
    } state_t;

    localparam int SCAN_DIV_DEFAULT = 50000;
    localparam int BUZZ_CYC_DEFAULT = 4;

    // Active-low one-hot code for an address up to 8 bits; callers truncate to their output width
    function automatic logic [255:0] onecold(input logic [7:0] sel);
        return ~(256'd1 << sel);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: DIV_W-bit step counter with clear/enable and a terminal-count pulse every DIV enabled clocks
module scan_prescaler #(
    parameter int DIV_W = 16,
    parameter int DIV   = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [DIV_W-1:0] cnt;

    assign tc = en && (cnt == DIV_W'(DIV - 1));

    // Count enabled clocks, returning to zero on clear or terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tc)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/scan_decoder_nx.sv
// scan_decoder_nx: registered N-to-2^N active-low decoder with 138-style enables, auto-scan and frame buzzer
// Optional macro SCAN_DECODER_BLANK_EN blanks y_n for the cycle of each scan step (anti-ghosting).
module scan_decoder_nx
    import scan_dec_pkg::*;
#(
    parameter  int SEL_W    = 3,
    parameter  int DIV_W    = 16,
    parameter  int SCAN_DIV = SCAN_DIV_DEFAULT,
    parameter  int BUZZ_CYC = BUZZ_CYC_DEFAULT,
    localparam int OUT_N    = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel,
    input  logic             g1,
    input  logic             g2a_n,
    input  logic             g2b_n,
    input  logic             mode,
    output logic [OUT_N-1:0] y_n,
    output logic [SEL_W-1:0] cur_sel,
    output logic             step,
    output logic             buzzer
);

    localparam int BW = $clog2(BUZZ_CYC + 1);
`ifdef SCAN_DECODER_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    state_t           st, nxt;
    logic             en, enter, load, run, tc, wrap, reload;
    logic [SEL_W-1:0] idx, idx_n;
    logic [BW-1:0]    bcnt;

    assign en     = g1 & ~g2a_n & ~g2b_n;
    assign nxt    = !en ? IDLE : (mode ? SCAN : DIRECT);
    assign enter  = (nxt == SCAN) && (st != SCAN);
    // A fresh scan starts at sel unless we are resuming after an enable glitch
    assign load   = enter && ((st == DIRECT) || reload);
    assign run    = (nxt == SCAN) && (st == SCAN);
    assign idx_n  = load ? sel : ((run && tc) ? idx + 1'b1 : idx);
    assign wrap   = run && tc && (&idx);
    assign buzzer = |bcnt;

    scan_prescaler #(
        .DIV_W(DIV_W),
        .DIV  (SCAN_DIV)
    ) u_pre (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  ((nxt == DIRECT) || load),
        .en   (run),
        .tc   (tc)
    );

    // FSM, scan index, resume flag, registered outputs and buzzer step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            idx     <= '0;
            reload  <= 1'b1;
            y_n     <= '1;
            cur_sel <= '0;
            step    <= 1'b0;
            bcnt    <= '0;
        end else begin
            st      <= nxt;
            idx     <= idx_n;
            reload  <= (st == SCAN) ? 1'b0 : (reload | ~mode | (st == DIRECT));
            step    <= run && tc;
            y_n     <= (nxt == IDLE || (BLANK && run && tc)) ? '1
                     : OUT_N'(onecold(8'((nxt == DIRECT) ? sel : idx_n)));
            cur_sel <= (nxt == IDLE) ? cur_sel : ((nxt == DIRECT) ? sel : idx_n);
            bcnt    <= !run ? '0
                     : wrap ? BW'(BUZZ_CYC)
                     : (tc && bcnt != '0) ? bcnt - 1'b1 : bcnt;
        end
    end

endmodule

// File: tb/tb_scan_decoder_nx.sv
// tb_scan_decoder_nx: directed literal checks plus randomized run against a behavioural model of scan_decoder_nx
module tb_scan_decoder_nx;

    localparam int DIV  = 4;
    localparam int BUZZ = 4;
`ifdef SCAN_DECODER_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, g1, g2a_n, g2b_n, mode;
    logic [2:0] sel;
    logic [7:0] y_n;
    logic [2:0] cur_sel;
    logic       step, buzzer;

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    // Model state: 0 idle, 1 direct, 2 scan
    int         ms = 0, idx = 0, pc = 0, brem = 0;
    bit         resumable = 1'b0;
    logic [7:0] m_y = 8'hFF;
    logic [2:0] m_cs = '0;
    logic       m_step = 1'b0, m_buzz = 1'b0;

    logic [7:0] dlit [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    scan_decoder_nx #(.SEL_W(3), .DIV_W(16), .SCAN_DIV(DIV), .BUZZ_CYC(BUZZ)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
        .mode(mode), .y_n(y_n), .cur_sel(cur_sel), .step(step), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] oc(input int k);
        return 8'hFF ^ (8'd1 << k);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_step();
        bit en_s, res_old;
        int prev;
        if (!rst_n) begin
            ms = 0; idx = 0; pc = 0; brem = 0; resumable = 1'b0;
            m_y = 8'hFF; m_cs = '0; m_step = 1'b0; m_buzz = 1'b0;
            return;
        end
        en_s = g1 && !g2a_n && !g2b_n;
        prev = ms;
        res_old = resumable;
        m_step = 1'b0;
        if (prev == 2) resumable = 1'b1;
        else if (prev == 1 || mode == 1'b0) resumable = 1'b0;
        if (!en_s) begin
            ms = 0; m_y = 8'hFF; brem = 0;
        end else if (!mode) begin
            ms = 1; pc = 0; m_y = oc(int'(sel)); m_cs = sel; brem = 0;
        end else if (prev != 2) begin
            ms = 2;
            if (prev == 1 || !res_old) begin idx = int'(sel); pc = 0; end
            m_y = oc(idx); m_cs = 3'(idx); brem = 0;
        end else begin
            if (pc == DIV - 1) begin
                pc = 0; m_step = 1'b1; idx = (idx + 1) % 8;
                if (idx == 0) brem = BUZZ;
                else if (brem > 0) brem--;
                m_y = BLANK ? 8'hFF : oc(idx);
            end else begin
                pc++; m_y = oc(idx);
            end
            m_cs = 3'(idx);
        end
        m_buzz = brem > 0;
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) if (cmp_on) begin
        chk("model_y_n", y_n, m_y);
        chk("model_cur_sel", cur_sel, m_cs);
        chk("model_step", step, m_step);
        chk("model_buzzer", buzzer, m_buzz);
    end

    initial begin
        rst_n = 1'b0; g1 = 1'b0; g2a_n = 1'b0; g2b_n = 1'b0; mode = 1'b0; sel = '0;
        repeat (2) @(negedge clk);
        chk("reset_y_n", y_n, 8'hFF);
        chk("reset_cur_sel", cur_sel, 0);
        chk("reset_step", step, 0);
        chk("reset_buzzer", buzzer, 0);
        rst_n = 1'b1;
        cmp_on = 1'b1;
        // Direct decode sweep
        g1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            @(negedge clk);
            chk("direct_y_n", y_n, dlit[i]);
            chk("direct_cur_sel", cur_sel, i);
            repeat (4) @(negedge clk);
        end
        // Each enable deasserted blanks the outputs and blocks sel
        for (int c = 0; c < 3; c++) begin
            {g1, g2a_n, g2b_n} = (c == 0) ? 3'b000 : (c == 1) ? 3'b110 : 3'b101;
            sel = 3'd5;
            @(negedge clk);
            chk("disabled_y_n", y_n, 8'hFF);
            sel = 3'd2;
            @(negedge clk);
            chk("disabled_sel_blocked", y_n, 8'hFF);
        end
        // Scan from 6 with wrap, buzzer, and an enable glitch at index 2
        {g1, g2a_n, g2b_n} = 3'b100;
        mode = 1'b1;
        sel = 3'd6;
        @(negedge clk);
        chk("scan_entry_y_n", y_n, 8'hBF);
        chk("scan_entry_step", step, 0);
        sel = 3'd1;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (k == 3) chk("scan_hold_y_n", y_n, 8'hBF);
            if (k == 4) begin chk("scan_step1", step, 1); chk("scan_step1_y_n", y_n, BLANK ? 8'hFF : 8'h7F); end
            if (k == 5) begin chk("scan_after_step_y_n", y_n, 8'h7F); chk("scan_no_step", step, 0); end
            if (k == 8) begin chk("wrap_y_n", y_n, BLANK ? 8'hFF : 8'hFE); chk("wrap_buzzer", buzzer, 1); chk("wrap_cur_sel", cur_sel, 0); end
            if (k == 9) chk("wrap_after_y_n", y_n, 8'hFE);
            if (k == 17) begin chk("idx2_y_n", y_n, 8'hFB); chk("buzzer_high", buzzer, 1); g1 = 1'b0; end
            if (k >= 18 && k <= 20) begin chk("glitch_y_n", y_n, 8'hFF); chk("glitch_step", step, 0); end
            if (k == 18) chk("glitch_buzzer", buzzer, 0);
            if (k == 20) g1 = 1'b1;
            if (k == 21) begin chk("resume_y_n", y_n, 8'hFB); chk("resume_cur_sel", cur_sel, 2); end
            if (k == 23) chk("resume_no_step", step, 0);
            if (k == 24) begin chk("resume_step", step, 1); chk("resume_next_cur_sel", cur_sel, 3); end
        end
        // Asynchronous reset between edges
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_y_n", y_n, 8'hFF);
        chk("async_cur_sel", cur_sel, 0);
        chk("async_buzzer", buzzer, 0);
        @(negedge clk);
        g1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle_y_n", y_n, 8'hFF);
        // Randomized run
        g1 = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            g1 = $urandom_range(0, 24) != 0;
            g2a_n = $urandom_range(0, 39) == 0;
            g2b_n = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 59) == 0) mode = ~mode;
            sel = 3'($urandom_range(0, 7));
            if (n == 2000) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(negedge clk);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_decoder_nx.md
Name: scan_decoder_nx

Overview:
Parametrised, registered N-to-2^N active-low line decoder with 74HCT138-style three-input enable (G1, /G2A, /G2B). It is the successor to the combinational 3-8 decoder. It adds an auto-scan mode: a prescaled counter walks the select address 0..2^N-1 to drive multiplexed display digits or LED columns. A buzzer output gives a frame-wrap marker. It sits between the board switches or timer logic and the digit/column drivers on the lab board.

Parameters:
SEL_W, 3, select width N; output count OUT_N = 2**SEL_W (localparam, derived)
DIV_W, 16, prescaler counter width
SCAN_DIV, 50000, clocks per scan step; legal range 2..2**DIV_W-1
BUZZ_CYC, 4, number of scan steps the buzzer stays high after a frame wrap

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
sel  in  SEL_W  direct-mode address; also the scan start address
g1  in  1  enable, active-high
g2a_n  in  1  enable, active-low
g2b_n  in  1  enable, active-low
mode  in  1  0 = direct decode, 1 = auto-scan
y_n  out  OUT_N  decoded outputs, active-low, one-cold
cur_sel  out  SEL_W  address currently decoded
step  out  1  one-cycle pulse on each scan advance
buzzer  out  1  frame marker, active-high

Behaviour:
- en = g1 & ~g2a_n & ~g2b_n, sampled each clk.
- Reset (asynchronous assert, synchronous release): y_n all ones, cur_sel=0, step=0, buzzer=0, prescaler=0, FSM=IDLE.
- FSM states:
  - IDLE: entered whenever en=0, from any state, on the next edge. y_n all ones; prescaler and scan index held.
  - DIRECT: entered when en=1 and mode=0.
  - SCAN: entered when en=1 and mode=1.
- DIRECT: y_n <= ~(1<<sel), cur_sel <= sel. One-cycle latency from sel/en change to y_n. Prescaler cleared. step=0.
- Entering SCAN from IDLE or DIRECT: scan index <= sel, prescaler <= 0, y_n decodes sel on that edge.
- SCAN: prescaler counts 0..SCAN_DIV-1. At terminal count:
  - prescaler <= 0
  - index <= index+1, wrapping 2**SEL_W-1 -> 0
  - step=1 for exactly that cycle
  - y_n and cur_sel update on the same edge as step.
- SCAN -> IDLE -> SCAN (enable glitch): index resumes from the held value, not sel, unless mode was 0 at any point during IDLE. Track this with a 1-bit reload flag.
- Buzzer: on the index wrap 2**SEL_W-1 -> 0, buzzer=1 for BUZZ_CYC step pulses, counted with an internal counter, then 0. A new wrap during buzzing restarts the count. Leaving SCAN clears buzzer on the next edge.
- Mode change 1->0 while enabled: DIRECT on the next edge, y_n follows sel.
- Any sel change in SCAN is ignored until SCAN is re-entered.
- Exactly one y_n bit is low in DIRECT/SCAN; none is low in IDLE. No X on any output after reset.

Optional Feature:
SCAN_DECODER_BLANK_EN
- Defined: in SCAN, y_n is forced to all ones for the single cycle in which step=1. The new address appears one cycle later. This is anti-ghosting blanking. cur_sel still updates with step.
- Undefined: no blanking; y_n switches directly on the step edge.

Decomposition:
- Shared package scan_dec_pkg:
  - state enum (IDLE, DIRECT, SCAN)
  - default constants SCAN_DIV_DEFAULT, BUZZ_CYC_DEFAULT
  - function onecold(sel) returning ~(1<<sel)
- One sub-module: scan_prescaler. It holds the DIV_W counter with clear/enable and emits a terminal-count pulse. It is reused by later display blocks.

Test Plan:
1. Reset, then g1=1, g2a_n=0, g2b_n=0, mode=0, sel stepped 0..7 every 50 ns -> one cycle after each change y_n = FE, FD, FB, F7, EF, DF, BF, 7F; cur_sel matches.
2. Enables (g1,g2a_n,g2b_n) = (0,0,0), (1,1,0), (1,0,1) with sel=5 -> y_n=FF next edge in each case; sel changes do not propagate.
3. SCAN_DIV=4, mode=1, sel=6 -> y_n=BF, then 7F after 4 clocks, then FE (wrap). step pulses every 4 clocks. buzzer rises at the wrap edge and stays high for 4 steps (16 clocks).
4. In SCAN, at index 2, drop g1 for 3 clocks then restore -> y_n=FF during the drop; resumes at index 2 with the prescaler not reset; no step during the drop.
5. Assert rst_n=0 mid-scan, between clock edges -> all outputs reset immediately (asynchronously); after release, state is IDLE with y_n=FF.
6. With SCAN_DECODER_BLANK_EN, repeat scenario 3 -> y_n=FF exactly on each step cycle, new code one cycle later; without the macro no FF cycles appear.
